vga_timing_gen: RTL and testbench

Free-running VGA timing generator for the 800x600@60 Hz mode on a 40 MHz pixel clock. It produces hcount/vcount, sync and blanking strobes that feed the background drawing stage directly. All outputs are registered and mutually aligned, so downstream stages can pipeline them without skew. It also emits a one-cycle frame-start pulse used by later stages to latch per-frame positions.

---
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen.sv | 86 ++++++++
 tb/tb_vga_timing_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Bundle of VGA timing outputs: counters plus sync/blank/frame strobes.
// The generator drives through master; downstream stages read through slave.
interface vga_timing_gen_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic        frame_start;

  modport master (
    output vcount, vsync, vblnk, hcount, hsync, hblnk, frame_start
  );

  modport slave (
    input  vcount, vsync, vblnk, hcount, hsync, hblnk, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing generator (800x600@60 Hz default, 40 MHz pixel clock).
// Every output is registered and derived from the same next-counter values.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FRONT  = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FRONT  = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BACK   = 23,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLK_BEG  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_BLK_BEG  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q,  hsync_d;
  logic        vsync_q,  vsync_d;
  logic        hblnk_q,  hblnk_d;
  logic        vblnk_q,  vblnk_d;
  logic        fstart_q, fstart_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (hcount_q < H_LAST) begin
      hcount_d = hcount_q + 11'd1;
    end else begin
      hcount_d = '0;
      if (vcount_q == V_LAST) vcount_d = '0;
      else                    vcount_d = vcount_q + 11'd1;
    end

    // Strobes decode the next counter values so they register alongside them.
    hblnk_d  = (hcount_d >= H_BLK_BEG);
    vblnk_d  = (vcount_d >= V_BLK_BEG);
    hsync_d  = ((hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    fstart_d = (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      fstart_q <= fstart_d;
    end
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.hblnk       = hblnk_q;
  assign vga.vblnk       = vblnk_q;
  assign vga.frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, reduced-size instances
// (32x20 total, both sync polarities) for frame, alignment and reset behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_full ();
  vga_timing_gen_if if_small ();
  vga_timing_gen_if if_small_n ();

  vga_timing_gen u_full (.clk(clk), .rst(rst), .vga(if_full));

  // Small geometry: H 16/4/8/4 (total 32), V 12/1/4/3 (total 20), frame 640 clocks.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(12), .V_FRONT(1), .V_SYNC(4), .V_BACK(3),
    .SYNC_POL(1'b1)
  ) u_small (.clk(clk), .rst(rst), .vga(if_small));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(12), .V_FRONT(1), .V_SYNC(4), .V_BACK(3),
    .SYNC_POL(1'b0)
  ) u_small_n (.clk(clk), .rst(rst), .vga(if_small_n));

  // Ends one time unit after a falling edge with counters at 0,0.
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (if_full.hcount !== 11'd0 || if_full.vcount !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_counters: h=%0d v=%0d, expected 0/0", if_full.hcount, if_full.vcount);
    end
    n_checks++;
    if ({if_full.hsync, if_full.vsync, if_full.hblnk, if_full.vblnk, if_full.frame_start} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_strobes: hs/vs/hb/vb/fs=%b, expected 00000",
               {if_full.hsync, if_full.vsync, if_full.hblnk, if_full.vblnk, if_full.frame_start});
    end
    n_checks++;
    if ({if_small_n.hsync, if_small_n.vsync} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_neg_sync: hs/vs=%b, expected 11", {if_small_n.hsync, if_small_n.vsync});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (if_full.hcount !== 11'd0 || if_full.vcount !== 11'd0 || if_full.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: h=%0d v=%0d fs=%b, expected 0/0/0",
               if_full.hcount, if_full.vcount, if_full.frame_start);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (if_full.hcount !== 11'd1 || if_full.vcount !== 11'd0 || if_full.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_edge: h=%0d v=%0d fs=%b, expected 1/0/0",
               if_full.hcount, if_full.vcount, if_full.frame_start);
    end
  endtask

  task automatic test_line_timing();
    int cnt_err = 0, blk_err = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
    int exp_h, exp_v;
    do_reset();
    for (int c = 0; c <= 1056; c++) begin
      exp_h = (c == 1056) ? 0 : c;
      exp_v = (c == 1056) ? 1 : 0;
      if (if_full.hcount !== 11'(exp_h) || if_full.vcount !== 11'(exp_v)) cnt_err++;
      if (if_full.hblnk !== ((c >= 800) && (c < 1056))) blk_err++;
      if (if_full.vblnk !== 1'b0 || if_full.frame_start !== 1'b0) blk_err++;
      if (if_full.hsync === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (cnt_err !== 0) begin
      n_fail++;
      $display("FAIL line_counters: %0d bad cycles, expected 0", cnt_err);
    end
    n_checks++;
    if (blk_err !== 0) begin
      n_fail++;
      $display("FAIL line_blanking: %0d bad cycles, expected 0", blk_err);
    end
    n_checks++;
    if (hs_cnt !== 128) begin
      n_fail++;
      $display("FAIL line_hsync_width: %0d clocks, expected 128", hs_cnt);
    end
    n_checks++;
    if (hs_first !== 840 || hs_last !== 967) begin
      n_fail++;
      $display("FAIL line_hsync_window: %0d..%0d, expected 840..967", hs_first, hs_last);
    end
  endtask

  task automatic test_frame_timing();
    int cnt_err = 0, strb_err = 0, vs_cnt = 0, vb_cnt = 0, fs_cnt = 0, fs_pos1 = -1, fs_pos2 = -1;
    int eh, ev;
    logic [4:0] exp_s;
    logic       wrap_ok = 1'b0;
    do_reset();
    for (int c = 0; c <= 1280; c++) begin
      eh = c % 32;
      ev = (c / 32) % 20;
      if (if_small.hcount !== 11'(eh) || if_small.vcount !== 11'(ev)) cnt_err++;
      exp_s = {eh >= 16, (eh >= 20) && (eh < 28), ev >= 12, (ev >= 13) && (ev < 17),
               (eh == 0) && (ev == 0) && (c != 0)};
      if ({if_small.hblnk, if_small.hsync, if_small.vblnk, if_small.vsync, if_small.frame_start} !== exp_s)
        strb_err++;
      if (if_small.vsync === 1'b1) vs_cnt++;
      if (if_small.vblnk === 1'b1) vb_cnt++;
      if (if_small.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_pos1 < 0) fs_pos1 = c; else fs_pos2 = c;
      end
      if (c == 640) wrap_ok = (if_small.hcount === 11'd0) && (if_small.vcount === 11'd0);
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (cnt_err !== 0) begin
      n_fail++;
      $display("FAIL frame_counters: %0d bad cycles, expected 0", cnt_err);
    end
    n_checks++;
    if (strb_err !== 0) begin
      n_fail++;
      $display("FAIL frame_strobes: %0d bad cycles, expected 0", strb_err);
    end
    n_checks++;
    if (vs_cnt !== 256) begin
      n_fail++;
      $display("FAIL frame_vsync_width: %0d clocks over 2 frames, expected 256", vs_cnt);
    end
    n_checks++;
    if (vb_cnt !== 512) begin
      n_fail++;
      $display("FAIL frame_vblank_width: %0d clocks over 2 frames, expected 512", vb_cnt);
    end
    n_checks++;
    if (fs_cnt !== 2 || fs_pos1 !== 640 || fs_pos2 !== 1280) begin
      n_fail++;
      $display("FAIL frame_start_pulses: count=%0d at %0d,%0d, expected 2 at 640,1280", fs_cnt, fs_pos1, fs_pos2);
    end
    n_checks++;
    if (wrap_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_wrap: wrap_ok=%b, expected 1", wrap_ok);
    end
  endtask

  task automatic test_alignment();
    int align_err = 0;
    int sh, sv;
    logic [4:0] exp_s;
    do_reset();
    for (int c = 0; c < 640; c++) begin
      sh = int'(if_small.hcount);
      sv = int'(if_small.vcount);
      exp_s = {sh >= 16, (sh >= 20) && (sh < 28), sv >= 12, (sv >= 13) && (sv < 17), (sh == 0) && (sv == 0) && (c != 0)};
      if ({if_small.hblnk, if_small.hsync, if_small.vblnk, if_small.vsync, if_small.frame_start} !== exp_s)
        align_err++;
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (align_err !== 0) begin
      n_fail++;
      $display("FAIL alignment: %0d misaligned cycles, expected 0", align_err);
    end
  endtask

  task automatic test_polarity();
    int pol_err = 0, hs_low = 0, vs_low = 0;
    int eh, ev;
    do_reset();
    for (int c = 0; c < 640; c++) begin
      eh = c % 32;
      ev = (c / 32) % 20;
      if (if_small_n.hcount !== 11'(eh) || if_small_n.vcount !== 11'(ev)) pol_err++;
      if (if_small_n.hblnk !== (eh >= 16) || if_small_n.vblnk !== (ev >= 12)) pol_err++;
      if (if_small_n.hsync !== !((eh >= 20) && (eh < 28))) pol_err++;
      if (if_small_n.vsync !== !((ev >= 13) && (ev < 17))) pol_err++;
      if (if_small_n.hsync === 1'b0) hs_low++;
      if (if_small_n.vsync === 1'b0) vs_low++;
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (pol_err !== 0) begin
      n_fail++;
      $display("FAIL polarity_outputs: %0d bad cycles, expected 0", pol_err);
    end
    n_checks++;
    if (hs_low !== 160 || vs_low !== 128) begin
      n_fail++;
      $display("FAIL polarity_widths: hs_low=%0d vs_low=%0d, expected 160/128", hs_low, vs_low);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    // Sample 470 = line 14, pixel 22: inside both hsync and vsync.
    repeat (470) @(negedge clk);
    #1;
    n_checks++;
    if (if_small.hcount !== 11'd22 || if_small.vcount !== 11'd14 ||
        if_small.hsync !== 1'b1 || if_small.vsync !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: h=%0d v=%0d hs=%b vs=%b, expected 22/14/1/1",
               if_small.hcount, if_small.vcount, if_small.hsync, if_small.vsync);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (if_small.hcount !== 11'd0 || if_small.vcount !== 11'd0 ||
        {if_small.hsync, if_small.vsync, if_small.hblnk, if_small.vblnk, if_small.frame_start} !== 5'b00000) begin
      n_fail++;
      $display("FAIL async_assert: h=%0d v=%0d strobes=%b, expected 0/0/00000", if_small.hcount, if_small.vcount,
               {if_small.hsync, if_small.vsync, if_small.hblnk, if_small.vblnk, if_small.frame_start});
    end
    n_checks++;
    if ({if_small_n.hsync, if_small_n.vsync} !== 2'b11 || if_full.hcount !== 11'd0) begin
      n_fail++;
      $display("FAIL async_assert_other: neg hs/vs=%b full_h=%0d, expected 11/0",
               {if_small_n.hsync, if_small_n.vsync}, if_full.hcount);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (if_small.hcount !== 11'd0 || if_small.hsync !== 1'b0) begin
      n_fail++;
      $display("FAIL async_hold: h=%0d hs=%b, expected 0/0", if_small.hcount, if_small.hsync);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (if_small.hcount !== 11'd1 || if_small.vcount !== 11'd0 ||
        if_small.hsync !== 1'b0 || if_small.vsync !== 1'b0 || if_small.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL async_resume: h=%0d v=%0d hs=%b vs=%b fs=%b, expected 1/0/0/0/0",
               if_small.hcount, if_small.vcount, if_small.hsync, if_small.vsync, if_small.frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_alignment();
    test_polarity();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
